// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// pc_fetch_ctrl : program counter, next-PC select, fetch handshake and trap redirect
// Revision 1.0
// ============================================================================
module pc_fetch_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pc_write_i,
    input  logic [2:0]  pc_source_i,
    input  logic [31:0] jalr_i,
    input  logic [31:0] branch_i,
    input  logic [31:0] jal_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        intr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ir_o,
    output logic        ir_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] trap_pc_o,
    output logic        misalign_o
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_VALID = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [2:0] SRC_JALR   = 3'd1;
    localparam logic [2:0] SRC_BRANCH = 3'd2;
    localparam logic [2:0] SRC_JAL    = 3'd3;
    localparam logic [2:0] SRC_MTVEC  = 3'd4;
    localparam logic [2:0] SRC_MEPC   = 3'd5;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic [31:0] ir_q;
    logic        ir_valid_q;
    logic [31:0] trap_pc_q;
    logic        misalign_q;

    logic [31:0] target;
    logic        target_misal;
    logic        ack;

    // An ack only counts while a request is actually on the bus.
    assign ack = imem_ack_i & imem_req_o;

    always_comb begin
        target = pc_q + 32'd4;
        case (pc_source_i)
            SRC_JALR:   target = {jalr_i[31:1], 1'b0};
            SRC_BRANCH: target = branch_i;
            SRC_JAL:    target = jal_i;
            SRC_MTVEC:  target = mtvec_i;
            SRC_MEPC:   target = mepc_i;
            default:    target = pc_q + 32'd4;
        endcase
    end

    assign target_misal = |target[1:0];

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (ack) begin
                    state_d = intr_i ? S_FETCH : S_VALID;
                end else if (intr_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_VALID: begin
                if (intr_i || pc_write_i) begin
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (ack) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Output logic; request is suppressed while reset is held.
    always_comb begin
        imem_req_o  = rst_ni && (state_q == S_FETCH || state_q == S_DRAIN);
        imem_addr_o = pc_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q       <= 32'd0;
            pend_q     <= 32'd0;
            ir_q       <= 32'd0;
            ir_valid_q <= 1'b0;
            trap_pc_q  <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (ack && !intr_i) begin
                        ir_q       <= imem_data_i;
                        ir_valid_q <= 1'b1;
                    end else if (intr_i) begin
                        trap_pc_q <= pc_q;
                        if (ack) begin
                            pc_q <= mtvec_i;
                        end else begin
                            pend_q <= mtvec_i;
                        end
                    end
                end
                S_VALID: begin
                    if (intr_i) begin
                        pc_q       <= mtvec_i;
                        trap_pc_q  <= pc_q;
                        ir_valid_q <= 1'b0;
                    end else if (pc_write_i) begin
                        ir_valid_q <= 1'b0;
                        if (target_misal) begin
                            pc_q       <= mtvec_i;
                            trap_pc_q  <= pc_q;
                            misalign_q <= 1'b1;
                        end else begin
                            pc_q <= target;
                        end
                    end
                end
                S_DRAIN: begin
                    // Address stays on the old PC until the stale response returns.
                    if (ack) begin
                        pc_q <= pend_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ir_o       = ir_q;
    assign ir_valid_o = ir_valid_q;
    assign pc_o       = pc_q;
    assign trap_pc_o  = trap_pc_q;
    assign misalign_o = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_ctrl : directed self-checking bench for pc_fetch_ctrl
// Revision 1.0
// ============================================================================
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic [2:0]  pc_source;
    logic [31:0] jalr, branch, jal, mtvec, mepc;
    logic        intr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc;
    logic [31:0] trap_pc;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    pc_fetch_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pc_write_i  (pc_write),
        .pc_source_i (pc_source),
        .jalr_i      (jalr),
        .branch_i    (branch),
        .jal_i       (jal),
        .mtvec_i     (mtvec),
        .mepc_i      (mepc),
        .intr_i      (intr),
        .imem_req_o  (imem_req),
        .imem_addr_o (imem_addr),
        .imem_ack_i  (imem_ack),
        .imem_data_i (imem_data),
        .ir_o        (ir),
        .ir_valid_o  (ir_valid),
        .pc_o        (pc),
        .trap_pc_o   (trap_pc),
        .misalign_o  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return one instruction word in the current FETCH cycle.
    task automatic respond(input logic [31:0] data);
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        imem_ack  = 1'b0;
    endtask

    task automatic redirect(input logic [2:0] src);
        pc_source = src;
        pc_write  = 1'b1;
        tick();
        pc_write  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pc_write = 1'b0; pc_source = 3'd0;
        jalr = '0; branch = '0; jal = '0; mtvec = 32'h200; mepc = '0;
        intr = 1'b0; imem_ack = 1'b0; imem_data = '0;
        tick(); tick();

        check("rst_pc",       pc, 32'h0);
        check("rst_ir",       ir, 32'h0);
        check("rst_irvalid",  {31'd0, ir_valid}, 32'd0);
        check("rst_trap",     trap_pc, 32'h0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_req",      {31'd0, imem_req}, 32'd0);

        rst_n = 1'b1;
        #1;
        check("rel_req",  {31'd0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, 32'h0);

        respond(32'h0000_0013);
        check("first_ir",      ir, 32'h0000_0013);
        check("first_irvalid", {31'd0, ir_valid}, 32'd1);
        check("first_pc",      pc, 32'h0);
        check("valid_noreq",   {31'd0, imem_req}, 32'd0);

        branch = 32'h40;
        redirect(3'd2);
        check("br_req",     {31'd0, imem_req}, 32'd1);
        check("br_addr",    imem_addr, 32'h40);
        check("br_irvalid", {31'd0, ir_valid}, 32'd0);
        respond(32'h0010_0093);
        check("br_pc", pc, 32'h40);

        jalr = 32'h103;
        redirect(3'd1);
        check("jalr_mis_pulse", {31'd0, misalign}, 32'd1);
        check("jalr_mis_pc",    pc, 32'h200);
        check("jalr_mis_trap",  trap_pc, 32'h40);
        tick();
        check("jalr_mis_once",  {31'd0, misalign}, 32'd0);
        respond(32'h0000_0001);

        jalr = 32'h101;
        redirect(3'd1);
        check("jalr_ok_pc",  pc, 32'h100);
        check("jalr_ok_mis", {31'd0, misalign}, 32'd0);

        branch = 32'h300;
        redirect(3'd2);
        check("fetch_ignore_pcw", imem_addr, 32'h100);

        respond(32'h0000_0002);
        jal = 32'h80;
        redirect(3'd3);
        check("jal_addr", imem_addr, 32'h80);

        intr = 1'b1;
        tick();
        check("drain_addr0", imem_addr, 32'h80);
        check("drain_req0",  {31'd0, imem_req}, 32'd1);
        check("drain_trap",  trap_pc, 32'h80);
        tick();
        check("drain_addr1", imem_addr, 32'h80);
        tick();
        check("drain_addr2", imem_addr, 32'h80);
        intr = 1'b0;
        respond(32'hDEAD_BEEF);
        check("drain_redirect", imem_addr, 32'h200);
        check("drain_irvalid",  {31'd0, ir_valid}, 32'd0);
        respond(32'h0000_0011);
        check("post_drain_ir", ir, 32'h0000_0011);
        check("post_drain_pc", pc, 32'h200);

        mtvec = 32'h240; jal = 32'h500; intr = 1'b1;
        redirect(3'd3);
        intr = 1'b0;
        check("intr_pcw_pc",   pc, 32'h240);
        check("intr_pcw_trap", trap_pc, 32'h200);

        mtvec = 32'h280; intr = 1'b1;
        respond(32'h0000_0BAD);
        intr = 1'b0;
        check("intr_ack_pc",      pc, 32'h280);
        check("intr_ack_irvalid", {31'd0, ir_valid}, 32'd0);
        check("intr_ack_trap",    trap_pc, 32'h240);
        check("intr_ack_ir",      ir, 32'h0000_0011);

        respond(32'h0000_0022);
        mepc = 32'h1234;
        redirect(3'd5);
        check("mepc_addr", imem_addr, 32'h1234);
        respond(32'h0000_0033);
        redirect(3'd0);
        check("pc4_addr", imem_addr, 32'h1238);

        respond(32'h0000_0044);
        branch = 32'hFFFF_FFFC;
        redirect(3'd2);
        respond(32'h0000_0055);
        redirect(3'd0);
        check("wrap_addr", imem_addr, 32'h0);
        respond(32'h0000_0066);
        redirect(3'd7);
        check("src7_addr", imem_addr, 32'h4);

        rst_n = 1'b0; imem_ack = 1'b1; imem_data = 32'h7777_7777;
        tick();
        check("mid_rst_pc",      pc, 32'h0);
        check("mid_rst_ir",      ir, 32'h0);
        check("mid_rst_irvalid", {31'd0, ir_valid}, 32'd0);
        check("mid_rst_req",     {31'd0, imem_req}, 32'd0);
        check("mid_rst_trap",    trap_pc, 32'h0);
        tick();
        check("late_ack_ignored", {31'd0, ir_valid}, 32'd0);
        rst_n = 1'b1; imem_ack = 1'b0;
        #1;
        check("rerel_addr", imem_addr, 32'h0);
        check("rerel_req",  {31'd0, imem_req}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
